// File: rtl/mem_access_stage.sv
// MEM-stage controller: runs a req/ack data-memory transaction for loads and
// stores, stalls the front of the pipeline meanwhile, and resolves branches.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  decoder_signals_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] regfile_2_i,
  input  logic [4:0]  regdst_i,
  input  logic [31:0] branch_adder_i,
  input  logic        alu_zero_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic [31:0] mem_rdata_o,
  output logic [6:0]  decoder_signals_o,
  output logic [31:0] alu_result_o,
  output logic [4:0]  regdst_o,
  output logic        branch_taken_o,
  output logic [31:0] branch_target_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        misalign_q, misalign_d;
  logic        timeout_q, timeout_d;

  logic mem_read, mem_write, branch, op;

  assign mem_read  = decoder_signals_i[0];
  assign mem_write = decoder_signals_i[1];
  assign branch    = decoder_signals_i[2];
  assign op        = mem_read | mem_write;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      cnt_q      <= 8'd0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (op) begin
          if (alu_result_i[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            rdata_d    = 32'd0;
            state_d    = DONE;
          end else begin
            addr_d  = alu_result_i;
            wdata_d = regfile_2_i;
            we_d    = mem_write;
            req_d   = 1'b1;
            cnt_d   = 8'd0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        // An ack in the final allowed cycle still completes the access.
        if (dmem_ack_i) begin
          req_d = 1'b0;
          if (!we_q) rdata_d = dmem_rdata_i;
          state_d = DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          req_d     = 1'b0;
          rdata_d   = 32'd0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall_o           = ((state_q == IDLE) && op) || (state_q == REQ);
  assign dmem_req_o        = req_q;
  assign dmem_we_o         = we_q;
  assign dmem_addr_o       = addr_q;
  assign dmem_wdata_o      = wdata_q;
  assign mem_rdata_o       = rdata_q;
  assign misalign_o        = misalign_q;
  assign timeout_o         = timeout_q;
  assign decoder_signals_o = decoder_signals_i;
  assign alu_result_o      = alu_result_i;
  assign regdst_o          = regdst_i;
  assign branch_taken_o    = branch & alu_zero_i;
  assign branch_target_o   = branch_adder_i;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, timeout, misalignment,
// branches and reset mid-transaction, with hand-computed expectations.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  dec;
  logic [31:0] alu, rs2, target, rdata_in;
  logic [4:0]  rd;
  logic        zero, ack;
  logic        req, we, stall, taken, misalign, tmo;
  logic [31:0] addr, wdata, mem_rdata, alu_out, target_out;
  logic [6:0]  dec_out;
  logic [4:0]  rd_out;

  int total = 0;
  int bad   = 0;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .decoder_signals_i(dec), .alu_result_i(alu), .regfile_2_i(rs2),
    .regdst_i(rd), .branch_adder_i(target), .alu_zero_i(zero),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_wdata_o(wdata),
    .dmem_ack_i(ack), .dmem_rdata_i(rdata_in),
    .stall_o(stall), .mem_rdata_o(mem_rdata),
    .decoder_signals_o(dec_out), .alu_result_o(alu_out), .regdst_o(rd_out),
    .branch_taken_o(taken), .branch_target_o(target_out),
    .misalign_o(misalign), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; inputs are then driven and outputs sampled mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; dec = '0; alu = '0; rs2 = '0; target = '0; rdata_in = '0;
    rd = '0; zero = 1'b0; ack = 1'b0;
    cyc(); cyc();
    #2;
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_flags", {29'd0, misalign, tmo, stall}, 32'd0);
    rst_n = 1'b1;

    // Load, ack on first REQ cycle
    dec = 7'b0000001; alu = 32'h100;
    #2 chk("ld_idle_stall", {31'd0, stall}, 32'd1);
    chk("ld_idle_req", {31'd0, req}, 32'd0);
    cyc(); ack = 1'b1; rdata_in = 32'hDEADBEEF;
    #2 chk("ld_req", {31'd0, req}, 32'd1);
    chk("ld_addr", addr, 32'h100);
    chk("ld_we", {31'd0, we}, 32'd0);
    chk("ld_req_stall", {31'd0, stall}, 32'd1);
    cyc(); ack = 1'b0;
    #2 chk("ld_done_req", {31'd0, req}, 32'd0);
    chk("ld_done_stall", {31'd0, stall}, 32'd0);
    chk("ld_rdata", mem_rdata, 32'hDEADBEEF);
    dec = '0;
    cyc();
    #2 chk("ld_idle_after", {31'd0, stall}, 32'd0);

    // Store, ack in third REQ cycle; an ack seen in IDLE is ignored
    dec = 7'b0000010; alu = 32'h40; rs2 = 32'h12345678; ack = 1'b1;
    #2 chk("st_idle_stall", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      ack = (i == 2);
      #2 chk("st_req", {31'd0, req}, 32'd1);
      chk("st_we", {31'd0, we}, 32'd1);
      chk("st_addr", addr, 32'h40);
      chk("st_wdata", wdata, 32'h12345678);
      chk("st_stall", {31'd0, stall}, 32'd1);
    end
    cyc(); ack = 1'b0;
    #2 chk("st_done_req", {31'd0, req}, 32'd0);
    chk("st_done_stall", {31'd0, stall}, 32'd0);
    chk("st_rdata_kept", mem_rdata, 32'hDEADBEEF);
    dec = '0;
    cyc();

    // Timeout with TIMEOUT=4
    dec = 7'b0000001; alu = 32'h200;
    #2 chk("to_idle_stall", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      #2 chk("to_req", {31'd0, req}, 32'd1);
      chk("to_stall", {31'd0, stall}, 32'd1);
      chk("to_no_pulse", {31'd0, tmo}, 32'd0);
    end
    cyc();
    #2 chk("to_pulse", {31'd0, tmo}, 32'd1);
    chk("to_done_req", {31'd0, req}, 32'd0);
    chk("to_done_stall", {31'd0, stall}, 32'd0);
    chk("to_rdata", mem_rdata, 32'd0);
    dec = '0;
    cyc();
    #2 chk("to_pulse_end", {31'd0, tmo}, 32'd0);
    chk("to_idle_stall2", {31'd0, stall}, 32'd0);

    // Misaligned load
    dec = 7'b0000001; alu = 32'h102;
    #2 chk("mis_idle_stall", {31'd0, stall}, 32'd1);
    cyc();
    #2 chk("mis_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_req", {31'd0, req}, 32'd0);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    chk("mis_rdata", mem_rdata, 32'd0);
    dec = '0;
    cyc();
    #2 chk("mis_pulse_end", {31'd0, misalign}, 32'd0);

    // Ack coinciding with the timeout cycle wins
    dec = 7'b0000001; alu = 32'h300;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) begin ack = 1'b1; rdata_in = 32'hCAFEF00D; end
      #2 chk("ack4_stall", {31'd0, stall}, 32'd1);
    end
    cyc(); ack = 1'b0;
    #2 chk("ack4_no_timeout", {31'd0, tmo}, 32'd0);
    chk("ack4_rdata", mem_rdata, 32'hCAFEF00D);
    chk("ack4_stall_done", {31'd0, stall}, 32'd0);
    dec = '0;
    cyc();

    // Branch resolution and pass-through fields
    dec = 7'b0000100; alu = 32'h55; rd = 5'd7; target = 32'h80; zero = 1'b1;
    #2 chk("br_taken", {31'd0, taken}, 32'd1);
    chk("br_target", target_out, 32'h80);
    chk("br_stall", {31'd0, stall}, 32'd0);
    chk("br_alu", alu_out, 32'h55);
    chk("br_rd", {27'd0, rd_out}, 32'd7);
    chk("br_dec", {25'd0, dec_out}, 32'h04);
    zero = 1'b0;
    #2 chk("br_not_taken", {31'd0, taken}, 32'd0);
    dec = 7'b1100000;
    #2 chk("rsv_dec", {25'd0, dec_out}, 32'h60);
    chk("rsv_stall", {31'd0, stall}, 32'd0);
    cyc();

    // Reset during REQ, then a normal load
    dec = 7'b0000010; alu = 32'h500; rs2 = 32'h0BADF00D;
    cyc();
    #2 chk("rr_req", {31'd0, req}, 32'd1);
    chk("rr_we", {31'd0, we}, 32'd1);
    rst_n = 1'b0; dec = '0;
    cyc();
    #2 chk("rr_req_cleared", {31'd0, req}, 32'd0);
    chk("rr_we_cleared", {31'd0, we}, 32'd0);
    chk("rr_addr", addr, 32'd0);
    chk("rr_wdata", wdata, 32'd0);
    chk("rr_rdata", mem_rdata, 32'd0);
    chk("rr_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1; dec = 7'b0000001; alu = 32'h104;
    cyc(); ack = 1'b1; rdata_in = 32'hA5A5A5A5;
    #2 chk("rr_ld_req", {31'd0, req}, 32'd1);
    chk("rr_ld_addr", addr, 32'h104);
    cyc(); ack = 1'b0;
    #2 chk("rr_ld_rdata", mem_rdata, 32'hA5A5A5A5);
    chk("rr_ld_stall", {31'd0, stall}, 32'd0);
    dec = '0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM-stage controller that sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register. It consumes the registered ALU result, store data, control bits, branch target and ALU zero flag. It runs a multi-cycle req/ack transaction to data memory for loads and stores, and stalls the front of the pipeline while that transaction is in flight. It also resolves branches and forwards the load data and writeback fields to MEM/WB.

Parameters:
TIMEOUT, 16, max cycles spent in REQ without dmem_ack_i before the access is aborted (legal range 1..255)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous, active-low reset
decoder_signals_i  in  7  from EX/MEM: [0] mem_read, [1] mem_write, [2] branch, [3] reg_write, [4] mem_to_reg, [6:5] reserved (passed through)
alu_result_i  in  32  from EX/MEM: memory address, or ALU writeback value
regfile_2_i  in  32  from EX/MEM: store data
regdst_i  in  5  from EX/MEM: destination register
branch_adder_i  in  32  from EX/MEM: branch target
alu_zero_i  in  1  from EX/MEM: ALU zero flag
dmem_req_o  out  1  data memory request, held high until ack
dmem_we_o  out  1  1 = write, 0 = read; valid while dmem_req_o is high
dmem_addr_o  out  32  word address, registered
dmem_wdata_o  out  32  store data, registered
dmem_ack_i  in  1  memory accepted/completed the access; dmem_rdata_i valid in the same cycle
dmem_rdata_i  in  32  read data
stall_o  out  1  drives keep_i of PC, IF/ID, ID/EX, EX/MEM and clear_i of MEM/WB
mem_rdata_o  out  32  load data to MEM/WB
decoder_signals_o  out  7  decoder_signals_i passed through combinationally
alu_result_o  out  32  alu_result_i passed through combinationally
regdst_o  out  5  regdst_i passed through combinationally
branch_taken_o  out  1  branch & alu_zero_i
branch_target_o  out  32  branch_adder_i passed through combinationally
misalign_o  out  1  one-cycle pulse: memory op with alu_result_i[1:0] != 0
timeout_o  out  1  one-cycle pulse: access aborted by TIMEOUT

Behaviour:
- Definition: op = mem_read | mem_write. If both bits are set, the access is a write.
- FSM states: IDLE, REQ, DONE. All state and registered outputs update only on the rising clock edge.
- Reset (rst_i == 0 at a clock edge): state <= IDLE; dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, mem_rdata_o, the timeout counter, misalign_o and timeout_o all <= 0.
- Reset mid-transaction abandons the request. Memory must tolerate dmem_req_o dropping without an ack.
- IDLE, op == 0: no stall; remain in IDLE.
- IDLE, op == 1, aligned address:
  - Latch dmem_addr_o <= alu_result_i, dmem_wdata_o <= regfile_2_i, dmem_we_o <= mem_write.
  - Set dmem_req_o <= 1 and clear the counter; go to REQ.
- IDLE, op == 1, misaligned address: no request issued; misalign_o pulses; mem_rdata_o <= 0; go to DONE.
- REQ:
  - dmem_req_o and all request fields are held stable; the counter increments each cycle.
  - On dmem_ack_i: dmem_req_o <= 0; mem_rdata_o <= dmem_rdata_i for a read, unchanged for a write; go to DONE.
  - When the counter reaches TIMEOUT-1 with no ack: dmem_req_o <= 0; mem_rdata_o <= 0; timeout_o pulses; go to DONE.
  - If ack and the timeout condition occur in the same cycle, the ack wins and timeout_o stays low.
- DONE: lasts exactly one cycle, with stall_o = 0 so EX/MEM and MEM/WB advance; then go to IDLE.
- stall_o (combinational) = (state == IDLE & op) | (state == REQ).
- Latency: a memory op holds the pipeline for a minimum of 2 stall cycles (IDLE, then REQ with immediate ack), followed by the DONE cycle. Maximum is 1 + TIMEOUT stall cycles.
- Back-to-back memory ops: the next op is detected in the IDLE cycle after DONE. There are no bubble cycles beyond the FSM sequence.
- dmem_ack_i in IDLE or DONE is ignored.
- Non-memory instructions pass with zero added latency.
- branch_taken_o and the pass-through outputs are combinational from the inputs. A branch is never a memory op, so it never coincides with stall_o.

Test Plan:
- Load, ack on the 1st REQ cycle: mem_read=1, addr=0x100, rdata=0xDEADBEEF -> stall_o high for 2 cycles; dmem_req_o/dmem_addr_o = 1/0x100 for 1 cycle; mem_rdata_o = 0xDEADBEEF in DONE with stall_o = 0.
- Store, ack after 3 cycles: mem_write=1, addr=0x40, wdata=0x12345678 -> dmem_we_o=1, fields stable for 3 REQ cycles; stall_o high for 4 cycles; mem_rdata_o unchanged.
- Timeout: TIMEOUT=4, load, no ack -> 4 REQ cycles, timeout_o pulses once, mem_rdata_o = 0, DONE then IDLE. Separately, ack in the 4th REQ cycle -> timeout_o stays 0.
- Misaligned load at addr=0x102 -> dmem_req_o stays 0, misalign_o pulses for 1 cycle, stall_o high for 1 cycle, mem_rdata_o = 0.
- Branch: branch=1, alu_zero_i=1, target=0x80 -> branch_taken_o=1, branch_target_o=0x80, stall_o=0. With alu_zero_i=0 -> branch_taken_o=0.
- Reset mid-REQ: rst_i low for 1 cycle during REQ -> dmem_req_o=0, state IDLE, all outputs 0 on the next cycle; a subsequent load completes normally.
